line_window_buffer: RTL and testbench
=====================================

// Module: line_window_buffer
// PURPOSE
//  Captures a window of NUM_LINES consecutive camera lines, starting at a runtime-selected line, into two ping-pong banks.
//  Sits between the camera pixel stream (VALID_DATA/CURRENT_LINE/CURRENT_COLUMN/DATA_IN) and downstream processing.
//  Capture continues into the free bank while the reader drains the ready bank.
// PARAMETERS
//  HEIGHT     480  lines per frame; CURRENT_LINE width LB = $clog2(HEIGHT)
//  WIDTH      752  pixels per line; CURRENT_COLUMN width CB = $clog2(WIDTH)
//  NUM_LINES  2    lines per window; LSB = max(1,$clog2(NUM_LINES))
//  DATA_BITS  10   pixel width
// PORTS
//  CLK             in   1          single clock for capture and read
//  RESET_N         in   1          asynchronous, active-low reset
//  VALID_DATA      in   1          pixel strobe from camera
//  CURRENT_LINE    in   LB         line index of current pixel
//  CURRENT_COLUMN  in   CB         column index of current pixel
//  DATA_IN         in   DATA_BITS  pixel value
//  START_LINE      in   LB         first line of window; sampled only at window start
//  READ_LINE_SEL   in   LSB        line within ready window to read
//  READ_ADDRESS    in   CB         column to read
//  RELEASE         in   1          pulse: reader done, free the ready bank
//  READY_FLAG      out  1          a complete window is readable
//  DATA_OUT        out  DATA_BITS  registered read data
//  OVERRUN         out  1          1-cycle pulse: window dropped, no free bank
//  ABORTED         out  1          1-cycle pulse: window discarded, line sequence broken
// BEHAVIOUR
//  Reset: all outputs 0; both banks FREE; write and read bank pointers 0.
//  Per-bank state: FREE -> FILLING -> READY -> FREE.
//  Window start: VALID_DATA & CURRENT_LINE==START_LINE & CURRENT_COLUMN==0.
//  - Write bank FREE: latch START_LINE, bank -> FILLING, write pixel to (line 0, col 0).
//  - Write bank not FREE: OVERRUN pulse next cycle; window ignored; no bank changes.
//  FILLING: each VALID_DATA pixel goes to (CURRENT_LINE - latched start, CURRENT_COLUMN).
//  - Pixel with line offset NUM_LINES-1 and column WIDTH-1: bank -> READY; write pointer toggles.
//  - CURRENT_LINE outside [start, start+NUM_LINES-1], or offset decreasing (frame restart):
//    bank -> FREE, ABORTED pulse; write pointer unchanged; offending pixel not written.
//  - START_LINE > HEIGHT-NUM_LINES: clamp to HEIGHT-NUM_LINES.
//  - START_LINE changes mid-window: ignored until the next window start.
//  READY_FLAG = state[read pointer]==READY; asserts the cycle after the last pixel is written.
//  Read: DATA_OUT = bank[read ptr][READ_LINE_SEL][READ_ADDRESS], 1-cycle latency; holds value when not READY.
//  RELEASE while READY: bank -> FREE, read pointer toggles; READY_FLAG drops next cycle,
//    or stays 1 if the other bank is already READY.
//  RELEASE while not READY: ignored.
//  Same-cycle RELEASE and window completion on the other bank: both take effect.
//  Same-cycle RELEASE and window start on the just-freed bank: bank is freed first, so capture starts.
//  Addresses are computed modulo physical RAM depth; out-of-range READ_ADDRESS returns undefined data.
//  RESET_N low mid-window: in-flight window lost; RAM contents not cleared.
// CONFIGURATION
//  LINE_WINDOW_SUM_EN defined:
//  - Adds output SUM_OUT [DATA_BITS+$clog2(NUM_LINES*WIDTH)-1:0], the per-bank sum of all pixels in the window.
//  - Sum accumulates during FILLING and clears at window start.
//  - SUM_OUT shows the read bank's sum, valid while READY_FLAG is 1; it is 0 after reset.
//  Not defined: no SUM_OUT port, no accumulators.
// STRUCTURE
//  Package line_window_pkg holds:
//  - bank state enum {FREE, FILLING, READY};
//  - width functions (LB, CB, LSB, SUM_W).
//  Sub-module line_window_bank_ram holds:
//  - simple dual-port RAM, depth NUM_LINES*WIDTH, registered read;
//  - two instances, one per bank.
//  Top level holds the bank FSMs, pointers, address generation and output mux.
// TESTING  (HEIGHT=3, WIDTH=2, NUM_LINES=2, START_LINE=1; pixels 11,12 / 21,22 / 31,32)
//  Stream starts mid-frame with no window start seen -> nothing written; READY_FLAG stays 0.
//  One frame -> READY_FLAG=1 the cycle after pixel 32; reads (0,0),(0,1),(1,0),(1,1) -> 21,22,31,32.
//  Second frame without RELEASE -> bank1 fills; RELEASE -> READY_FLAG stays 1; reads return frame-2 data.
//  Third frame with both banks READY -> OVERRUN pulses once at (line1,col0); bank contents unchanged.
//  Frame restart (line 0) after pixel 21 -> ABORTED pulses; READY_FLAG stays 0; next full frame -> READY.
//  START_LINE=2 -> clamps to 1, so data matches scenario 2.
//  RESET_N low mid-window -> outputs 0 immediately.
//  LINE_WINDOW_SUM_EN -> SUM_OUT=106 after one frame.

Source files
------------

// File: rtl/line_window_pkg.sv
// Shared types and width helpers for the line window capture buffer.
package line_window_pkg;

  // Lifecycle of one ping-pong bank.
  typedef enum logic [1:0] {
    FREE    = 2'd0,
    FILLING = 2'd1,
    READY   = 2'd2
  } bank_state_e;

  // Widths never collapse below one bit, so degenerate parameters still elaborate.
  function automatic int clog2_min1(input int n);
    int r;
    r = $clog2(n);
    return (r < 1) ? 1 : r;
  endfunction

  function automatic int lb(input int height);
    return clog2_min1(height);
  endfunction

  function automatic int cb(input int width);
    return clog2_min1(width);
  endfunction

  function automatic int lsb(input int num_lines);
    return clog2_min1(num_lines);
  endfunction

  function automatic int sum_w(input int data_bits, input int num_lines, input int width);
    return data_bits + $clog2(num_lines * width);
  endfunction

endpackage

// File: rtl/line_window_bank_ram.sv
// One window bank: simple dual-port RAM with a registered, enable-gated read port.
// The read register holds its value while re is low.
module line_window_bank_ram
  import line_window_pkg::*;
#(
  parameter int DATA_BITS = 10,
  parameter int DEPTH     = 1504,
  localparam int AW       = clog2_min1(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 we,
  input  logic [AW-1:0]        waddr,
  input  logic [DATA_BITS-1:0] wdata,
  input  logic                 re,
  input  logic [AW-1:0]        raddr,
  output logic [DATA_BITS-1:0] rdata
);

  logic [DATA_BITS-1:0] mem_q [DEPTH];
  logic [DATA_BITS-1:0] rdata_q;
  logic [DATA_BITS-1:0] rdata_d;

  // Pixel storage: written by capture, never reset.
  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  // Read data only advances on an enabled read.
  always_comb begin
    rdata_d = re ? mem_q[raddr] : rdata_q;
  end

  // Read output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdata_q <= '0;
    else        rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/line_window_buffer.sv
// Captures NUM_LINES consecutive camera lines from a runtime start line into
// two ping-pong banks; the reader drains the ready bank while capture fills
// the other. Optional per-bank pixel sum output under LINE_WINDOW_SUM_EN.
module line_window_buffer
  import line_window_pkg::*;
#(
  parameter int HEIGHT    = 480,
  parameter int WIDTH     = 752,
  parameter int NUM_LINES = 2,
  parameter int DATA_BITS = 10,
  localparam int LB       = lb(HEIGHT),
  localparam int CB       = cb(WIDTH),
  localparam int LSB      = lsb(NUM_LINES),
  localparam int SUM_W    = sum_w(DATA_BITS, NUM_LINES, WIDTH)
) (
  input  logic                 CLK,
  input  logic                 RESET_N,
  input  logic                 VALID_DATA,
  input  logic [LB-1:0]        CURRENT_LINE,
  input  logic [CB-1:0]        CURRENT_COLUMN,
  input  logic [DATA_BITS-1:0] DATA_IN,
  input  logic [LB-1:0]        START_LINE,
  input  logic [LSB-1:0]       READ_LINE_SEL,
  input  logic [CB-1:0]        READ_ADDRESS,
  input  logic                 RELEASE,
  output logic                 READY_FLAG,
  output logic [DATA_BITS-1:0] DATA_OUT,
  output logic                 OVERRUN,
  output logic                 ABORTED
`ifdef LINE_WINDOW_SUM_EN
  ,
  output logic [SUM_W-1:0]     SUM_OUT
`endif
);

  localparam int DEPTH     = NUM_LINES * WIDTH;
  localparam int AW        = clog2_min1(DEPTH);
  localparam int MAX_START = HEIGHT - NUM_LINES;

  bank_state_e state_q [2];
  bank_state_e state_d [2];
  logic        wr_ptr_q, wr_ptr_d;
  logic        rd_ptr_q, rd_ptr_d;
  logic        rd_sel_q, rd_sel_d;
  logic [LB-1:0]  start_q, start_d;
  logic [LSB-1:0] last_off_q, last_off_d;
  logic        overrun_q, overrun_d;
  logic        aborted_q, aborted_d;

  logic [LB-1:0]  start_clamped;
  logic           win_start;
  logic [31:0]    fill_off;
  logic           in_window;
  logic           off_backwards;
  logic           fill_last;
  logic           start_last;
  logic [AW-1:0]  fill_addr;
  logic [AW-1:0]  start_addr;
  logic [AW-1:0]  waddr;
  logic [AW-1:0]  raddr;
  logic           wr_en;
  logic           wr_start;
  logic           ready_flag;
  logic [DATA_BITS-1:0] rdata [2];

  // Window detection and write/read address generation.
  always_comb begin
    start_clamped = (32'(START_LINE) > 32'(MAX_START)) ? LB'(MAX_START) : START_LINE;
    win_start     = (CURRENT_LINE == start_clamped) && (CURRENT_COLUMN == '0);
    // Lines before the latched start wrap to a huge offset and fall out of window.
    fill_off      = 32'(CURRENT_LINE) - 32'(start_q);
    in_window     = fill_off < 32'(NUM_LINES);
    off_backwards = fill_off < 32'(last_off_q);
    fill_last     = (fill_off == 32'(NUM_LINES - 1)) &&
                    (32'(CURRENT_COLUMN) == 32'(WIDTH - 1));
    start_last    = (NUM_LINES == 1) && (32'(CURRENT_COLUMN) == 32'(WIDTH - 1));
    fill_addr     = AW'((fill_off * 32'(WIDTH) + 32'(CURRENT_COLUMN)) % 32'(DEPTH));
    start_addr    = AW'(32'(CURRENT_COLUMN) % 32'(DEPTH));
    raddr         = AW'((32'(READ_LINE_SEL) * 32'(WIDTH) + 32'(READ_ADDRESS)) % 32'(DEPTH));
  end

  assign ready_flag = (state_q[rd_ptr_q] == READY);

  // Bank FSMs and pointers; release is applied before capture so a bank
  // freed this cycle can immediately accept a new window.
  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    start_d    = start_q;
    last_off_d = last_off_q;
    overrun_d  = 1'b0;
    aborted_d  = 1'b0;
    wr_en      = 1'b0;
    wr_start   = 1'b0;
    waddr      = fill_addr;
    rd_sel_d   = ready_flag ? rd_ptr_q : rd_sel_q;

    if (RELEASE && (state_q[rd_ptr_q] == READY)) begin
      state_d[rd_ptr_q] = FREE;
      rd_ptr_d          = ~rd_ptr_q;
    end

    if (VALID_DATA) begin
      case (state_d[wr_ptr_q])
        FREE: begin
          if (win_start) begin
            state_d[wr_ptr_q] = FILLING;
            start_d           = start_clamped;
            last_off_d        = '0;
            wr_en             = 1'b1;
            wr_start          = 1'b1;
            waddr             = start_addr;
            if (start_last) begin
              state_d[wr_ptr_q] = READY;
              wr_ptr_d          = ~wr_ptr_q;
            end
          end
        end
        FILLING: begin
          if (in_window && !off_backwards) begin
            wr_en      = 1'b1;
            last_off_d = LSB'(fill_off);
            if (fill_last) begin
              state_d[wr_ptr_q] = READY;
              wr_ptr_d          = ~wr_ptr_q;
            end
          end else begin
            state_d[wr_ptr_q] = FREE;
            aborted_d         = 1'b1;
          end
        end
        READY: begin
          if (win_start) overrun_d = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Control state registers.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q    <= '{FREE, FREE};
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      rd_sel_q   <= 1'b0;
      start_q    <= '0;
      last_off_q <= '0;
      overrun_q  <= 1'b0;
      aborted_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      rd_sel_q   <= rd_sel_d;
      start_q    <= start_d;
      last_off_q <= last_off_d;
      overrun_q  <= overrun_d;
      aborted_q  <= aborted_d;
    end
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    line_window_bank_ram #(
      .DATA_BITS (DATA_BITS),
      .DEPTH     (DEPTH)
    ) u_ram (
      .clk   (CLK),
      .rst_n (RESET_N),
      .we    (wr_en && (wr_ptr_q == 1'(b))),
      .waddr (waddr),
      .wdata (DATA_IN),
      .re    (ready_flag && (rd_ptr_q == 1'(b))),
      .raddr (raddr),
      .rdata (rdata[b])
    );
  end

  assign READY_FLAG = ready_flag;
  assign DATA_OUT   = rdata[rd_sel_q];
  assign OVERRUN    = overrun_q;
  assign ABORTED    = aborted_q;

`ifdef LINE_WINDOW_SUM_EN
  logic [SUM_W-1:0] sum_q [2];
  logic [SUM_W-1:0] sum_d [2];

  // Per-bank accumulator: restarts with the first pixel of each window.
  always_comb begin
    sum_d = sum_q;
    if (wr_en) begin
      sum_d[wr_ptr_q] = wr_start ? SUM_W'(DATA_IN)
                                 : sum_q[wr_ptr_q] + SUM_W'(DATA_IN);
    end
  end

  // Accumulator registers.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) sum_q <= '{'0, '0};
    else          sum_q <= sum_d;
  end

  assign SUM_OUT = sum_q[rd_ptr_q];
`endif

endmodule

// File: tb/tb_line_window_buffer.sv
// Directed bench for line_window_buffer with HEIGHT=3, WIDTH=2, NUM_LINES=2.
// Frame pixels are base + 11,12 / 21,22 / 31,32 for lines 0/1/2.
module tb_line_window_buffer;

  logic       clk;
  logic       rst_n;
  logic       valid;
  logic [1:0] cur_line;
  logic [0:0] cur_col;
  logic [9:0] din;
  logic [1:0] start_line;
  logic [0:0] rd_sel;
  logic [0:0] rd_addr;
  logic       rel;
  logic       ready;
  logic [9:0] dout;
  logic       overrun;
  logic       aborted;
`ifdef LINE_WINDOW_SUM_EN
  logic [11:0] sum_out;
`endif

  int errors = 0;
  int checks = 0;

  line_window_buffer #(
    .HEIGHT    (3),
    .WIDTH     (2),
    .NUM_LINES (2),
    .DATA_BITS (10)
  ) dut (
    .CLK            (clk),
    .RESET_N        (rst_n),
    .VALID_DATA     (valid),
    .CURRENT_LINE   (cur_line),
    .CURRENT_COLUMN (cur_col),
    .DATA_IN        (din),
    .START_LINE     (start_line),
    .READ_LINE_SEL  (rd_sel),
    .READ_ADDRESS   (rd_addr),
    .RELEASE        (rel),
    .READY_FLAG     (ready),
    .DATA_OUT       (dout),
    .OVERRUN        (overrun),
    .ABORTED        (aborted)
`ifdef LINE_WINDOW_SUM_EN
    ,
    .SUM_OUT        (sum_out)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one pixel at the falling edge; return 1 time unit after it is sampled.
  task automatic pix(input int l, input int c, input int d);
    @(negedge clk);
    valid    = 1'b1;
    cur_line = 2'(l);
    cur_col  = 1'(c);
    din      = 10'(d);
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    @(negedge clk);
    valid = 1'b0;
  endtask

  task automatic send_frame(input int base);
    for (int l = 0; l < 3; l++)
      for (int c = 0; c < 2; c++)
        pix(l, c, base + (l + 1) * 10 + c + 1);
    idle();
  endtask

  task automatic rd(input int sel, input int addr, output logic [9:0] v);
    @(negedge clk);
    rd_sel  = 1'(sel);
    rd_addr = 1'(addr);
    @(posedge clk);
    #1;
    v = dout;
  endtask

  task automatic do_release();
    @(negedge clk);
    rel = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    rel = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; valid = 1'b0; cur_line = '0; cur_col = '0; din = '0;
    start_line = 2'd1; rd_sel = '0; rd_addr = '0; rel = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (ready !== 1'b0)   begin errors++; $display("FAIL reset_ready got=%b exp=0", ready); end
    checks++; if (dout !== 10'd0)   begin errors++; $display("FAIL reset_dout got=%0d exp=0", dout); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun got=%b exp=0", overrun); end
    checks++; if (aborted !== 1'b0) begin errors++; $display("FAIL reset_aborted got=%b exp=0", aborted); end
`ifdef LINE_WINDOW_SUM_EN
    checks++; if (sum_out !== 12'd0) begin errors++; $display("FAIL reset_sum got=%0d exp=0", sum_out); end
`endif
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_no_start();
    pix(2, 0, 31);
    pix(2, 1, 32);
    pix(1, 1, 22);
    idle();
    @(posedge clk); #1;
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL no_start_ready got=%b exp=0", ready); end
  endtask

  task automatic test_single_frame();
    int exp_tbl [4] = '{21, 22, 31, 32};
    logic [9:0] v;
    for (int l = 0; l < 3; l++)
      for (int c = 0; c < 2; c++) begin
        pix(l, c, (l + 1) * 10 + c + 1);
        if (l == 2 && c == 0) begin
          checks++; if (ready !== 1'b0) begin errors++; $display("FAIL frame1_ready_early got=%b exp=0", ready); end
        end
      end
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL frame1_ready got=%b exp=1", ready); end
    idle();
    for (int i = 0; i < 4; i++) begin
      rd(i / 2, i % 2, v);
      checks++;
      if (v !== 10'(exp_tbl[i])) begin
        errors++; $display("FAIL frame1_read%0d got=%0d exp=%0d", i, v, exp_tbl[i]);
      end
    end
  endtask

  task automatic test_double_buffer();
    int exp1 [4] = '{21, 22, 31, 32};
    int exp2 [4] = '{121, 122, 131, 132};
    int ovr_cnt;
    logic [9:0] v;
    send_frame(100);
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL frame2_ready got=%b exp=1", ready); end
    ovr_cnt = 0;
    for (int l = 0; l < 3; l++)
      for (int c = 0; c < 2; c++) begin
        pix(l, c, 200 + (l + 1) * 10 + c + 1);
        if (overrun === 1'b1) ovr_cnt++;
        if (l == 1 && c == 0) begin
          checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL overrun_pulse got=%b exp=1", overrun); end
        end
      end
    idle();
    checks++; if (ovr_cnt != 1) begin errors++; $display("FAIL overrun_count got=%0d exp=1", ovr_cnt); end
    for (int i = 0; i < 4; i++) begin
      rd(i / 2, i % 2, v);
      checks++;
      if (v !== 10'(exp1[i])) begin errors++; $display("FAIL bank0_kept%0d got=%0d exp=%0d", i, v, exp1[i]); end
    end
    do_release();
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL release_ready_stays got=%b exp=1", ready); end
    for (int i = 0; i < 4; i++) begin
      rd(i / 2, i % 2, v);
      checks++;
      if (v !== 10'(exp2[i])) begin errors++; $display("FAIL frame2_read%0d got=%0d exp=%0d", i, v, exp2[i]); end
    end
    do_release();
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL release_ready_drops got=%b exp=0", ready); end
    do_release();
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL release_idle got=%b exp=0", ready); end
  endtask

  task automatic test_abort();
    logic [9:0] v;
    pix(0, 0, 11);
    pix(0, 1, 12);
    pix(1, 0, 21);
    checks++; if (aborted !== 1'b0) begin errors++; $display("FAIL abort_early got=%b exp=0", aborted); end
    pix(0, 0, 11);
    checks++; if (aborted !== 1'b1) begin errors++; $display("FAIL abort_pulse got=%b exp=1", aborted); end
    checks++; if (ready !== 1'b0)   begin errors++; $display("FAIL abort_ready got=%b exp=0", ready); end
    pix(0, 1, 12);
    checks++; if (aborted !== 1'b0) begin errors++; $display("FAIL abort_width got=%b exp=0", aborted); end
    idle();
    send_frame(300);
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL abort_recover_ready got=%b exp=1", ready); end
    rd(0, 0, v);
    checks++; if (v !== 10'd321) begin errors++; $display("FAIL abort_recover_r00 got=%0d exp=321", v); end
    rd(1, 1, v);
    checks++; if (v !== 10'd332) begin errors++; $display("FAIL abort_recover_r11 got=%0d exp=332", v); end
    do_release();
  endtask

  task automatic test_clamp();
    int exp_tbl [4] = '{421, 422, 431, 432};
    logic [9:0] v;
    @(negedge clk);
    start_line = 2'd2;
    send_frame(400);
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL clamp_ready got=%b exp=1", ready); end
    for (int i = 0; i < 4; i++) begin
      rd(i / 2, i % 2, v);
      checks++;
      if (v !== 10'(exp_tbl[i])) begin errors++; $display("FAIL clamp_read%0d got=%0d exp=%0d", i, v, exp_tbl[i]); end
    end
    do_release();
    start_line = 2'd1;
  endtask

  task automatic test_reset_mid_window();
    logic [9:0] v;
    send_frame(500);
    rd(1, 1, v);
    checks++; if (v !== 10'd532) begin errors++; $display("FAIL pre_reset_read got=%0d exp=532", v); end
    pix(0, 0, 511);
    pix(0, 1, 512);
    pix(1, 0, 521);
    @(negedge clk);
    valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checks++; if (ready !== 1'b0)   begin errors++; $display("FAIL midrst_ready got=%b exp=0", ready); end
    checks++; if (dout !== 10'd0)   begin errors++; $display("FAIL midrst_dout got=%0d exp=0", dout); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL midrst_overrun got=%b exp=0", overrun); end
    checks++; if (aborted !== 1'b0) begin errors++; $display("FAIL midrst_aborted got=%b exp=0", aborted); end
    @(negedge clk);
    rst_n = 1'b1;
    send_frame(600);
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL postrst_ready got=%b exp=1", ready); end
    rd(0, 1, v);
    checks++; if (v !== 10'd622) begin errors++; $display("FAIL postrst_read got=%0d exp=622", v); end
  endtask

`ifdef LINE_WINDOW_SUM_EN
  task automatic test_sum();
    do_release();
    send_frame(0);
    checks++; if (ready !== 1'b1)    begin errors++; $display("FAIL sum_ready got=%b exp=1", ready); end
    checks++; if (sum_out !== 12'd106) begin errors++; $display("FAIL sum_value got=%0d exp=106", sum_out); end
  endtask
`endif

  initial begin
    test_reset();
    test_no_start();
    test_single_frame();
    test_double_buffer();
    test_abort();
    test_clamp();
    test_reset_mid_window();
`ifdef LINE_WINDOW_SUM_EN
    test_sum();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
